// File: rtl/count_sched_pkg.sv
// Shared types and defaults for the counting-job scheduler.
// Optional feature macro: ARB_RR_EN (round-robin arbitration when defined).
package count_sched_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned IDX_W_DEF = $clog2(NREQ_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/count_rr_arb.sv
// Requester arbiter: masks the just-served requester, then picks one request.
// With ARB_RR_EN defined the search starts after the last grant (round robin);
// otherwise the lowest index wins and no pointer state exists.
module count_rr_arb
    import count_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
`ifdef ARB_RR_EN
    input  logic             clk,
    input  logic             clr_n,
    input  logic             adv_i,
`endif
    input  logic [NREQ-1:0]  req,
    input  logic             mask_en_i,
    input  logic [IDX_W-1:0] mask_idx_i,
    output logic [NREQ-1:0]  gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [NREQ-1:0] req_m;

    // Drop the requester served last time for one IDLE cycle.
    always_comb begin
        req_m = req;
        if (mask_en_i) begin
            req_m[mask_idx_i] = 1'b0;
        end
    end

`ifdef ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;

    // Round-robin search beginning at the pointer.
    always_comb begin
        int j;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!gnt_valid_o && req_m[j]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'(j);
            end
        end
    end

    // Pointer moves to the slot after each accepted grant.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= (int'(gnt_idx_o) == NREQ - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_valid_o && req_m[k]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'(k);
            end
        end
    end
`endif

    assign gnt_oh_o = gnt_valid_o ? (NREQ'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/count_job_sched.sv
// Shares one W-bit loadable up/down counter among NREQ requesters.
// A job is granted in IDLE, loaded in LOAD, stepped in RUN and reported in DONE.
// Handshake: req stays high until its done pulse; inputs are latched at grant,
// so later changes to req/mode/start_val/end_val are ignored while granted.
// Optional feature macro: ARB_RR_EN (round-robin arbitration when defined).
module count_job_sched
    import count_sched_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mode,
    input  logic [NREQ*W-1:0] start_val,
    input  logic [NREQ*W-1:0] end_val,
    input  logic            abort,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            err,
    output logic            busy,
    output logic [W-1:0]    count,
    output state_e          state_dbg
);

    localparam int IDX_W = $clog2(NREQ);

    state_e           state_q;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic             err_q;
    logic             mask_q;
    logic [IDX_W-1:0] idx_q;
    logic             mode_q;
    logic [W-1:0]     start_q;
    logic [W-1:0]     end_q;
    logic [W-1:0]     count_q;
    logic [W-1:0]     count_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    count_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
`ifdef ARB_RR_EN
        .clk         (clk),
        .clr_n       (clr_n),
        .adv_i       (state_q == IDLE && arb_valid),
`endif
        .req         (req),
        .mask_en_i   (mask_q),
        .mask_idx_i  (idx_q),
        .gnt_oh_o    (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    // One modulo-2^W step in the latched direction.
    always_comb begin
        count_d = mode_q ? (count_q + 1'b1) : (count_q - 1'b1);
    end

    // Job FSM together with the counter datapath; all outputs registered.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            mask_q  <= 1'b0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            start_q <= '0;
            end_q   <= '0;
            count_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            mask_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        state_q <= LOAD;
                        gnt_q   <= arb_gnt;
                        idx_q   <= arb_idx;
                        mode_q  <= mode[arb_idx];
                        start_q <= start_val[int'(arb_idx)*W +: W];
                        end_q   <= end_val[int'(arb_idx)*W +: W];
                    end
                end
                LOAD: begin
                    count_q <= start_q;
                    state_q <= RUN;
                end
                RUN: begin
                    if (abort) begin
                        state_q <= DONE;
                        gnt_q   <= '0;
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                    end else if (count_q == end_q) begin
                        state_q <= DONE;
                        gnt_q   <= '0;
                        done_q  <= gnt_q;
                    end else begin
                        count_q <= count_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    mask_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign count     = count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_count_job_sched.sv
// Directed bench for count_job_sched (W=8, NREQ=4).
// Inputs change #1 after posedge or on negedge; outputs are sampled on negedge.
module tb_count_job_sched;
    import count_sched_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  mode = '0;
    logic [31:0] start_val = '0;
    logic [31:0] end_val = '0;
    logic        abort = 1'b0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [7:0]  count;
    state_e      state_dbg;

    int n_pass = 0;
    int n_total = 0;

    count_job_sched #(.W(8), .NREQ(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req),
        .mode      (mode),
        .start_val (start_val),
        .end_val   (end_val),
        .abort     (abort),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .count     (count),
        .state_dbg (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic set_job(input int i, input logic m, input logic [7:0] s, input logic [7:0] e);
        mode[i] = m;
        start_val[i*8 +: 8] = s;
        end_val[i*8 +: 8] = e;
    endtask

    // Drive req at the start of cycle 0.
    task automatic post_req(input logic [3:0] r);
        @(posedge clk);
        #1;
        req = r;
    endtask

    task automatic wait_idle(input string name);
        int ok;
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        n_total++;
        if (ok != 1) $display("FAIL %s_idle_timeout: busy=%0b required 0", name, busy);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++; if (count !== 8'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
        n_total++; if (gnt !== 4'b0) $display("FAIL rst_gnt: got %b want 0000", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (state_dbg !== IDLE) $display("FAIL rst_state: got %0d want 0", state_dbg); else n_pass++;
        #1 clr_n = 1'b1;
        @(negedge clk);
        n_total++; if (done !== 4'b0 || err !== 1'b0) $display("FAIL rst_done_err: got %b/%b want 0000/0", done, err); else n_pass++;
    endtask

    task automatic test_up_job();
        logic [3:0] eg;
        logic [3:0] ed;
        set_job(1, 1'b1, 8'd10, 8'd13);
        post_req(4'b0010);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            eg = (c >= 1 && c <= 5) ? 4'b0010 : 4'b0000;
            ed = (c == 6) ? 4'b0010 : 4'b0000;
            n_total++; if (gnt !== eg) $display("FAIL up_gnt c%0d: got %b want %b", c, gnt, eg); else n_pass++;
            n_total++; if (done !== ed) $display("FAIL up_done c%0d: got %b want %b", c, done, ed); else n_pass++;
            if (c >= 2 && c <= 5) begin
                n_total++; if (count !== 8'(8 + c)) $display("FAIL up_count c%0d: got %0d want %0d", c, count, 8 + c); else n_pass++;
            end
            if (c == 6) begin
                n_total++; if (err !== 1'b0) $display("FAIL up_err: got %b want 0", err); else n_pass++;
                req = 4'b0;
            end
        end
        wait_idle("up");
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp_cnt [5];
        exp_cnt = '{8'd2, 8'd1, 8'd0, 8'd255, 8'd254};
        set_job(0, 1'b0, 8'd2, 8'd254);
        post_req(4'b0001);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                n_total++; if (count !== exp_cnt[c-2]) $display("FAIL down_count c%0d: got %0d want %0d", c, count, exp_cnt[c-2]); else n_pass++;
                n_total++; if (done !== 4'b0) $display("FAIL down_early_done c%0d: got %b want 0000", c, done); else n_pass++;
            end
            if (c == 7) begin
                n_total++; if (done !== 4'b0001) $display("FAIL down_done: got %b want 0001", done); else n_pass++;
                n_total++; if (count !== 8'd254) $display("FAIL down_final: got %0d want 254", count); else n_pass++;
                req = 4'b0;
            end
        end
        wait_idle("down");
    endtask

    task automatic test_arbitration();
        int order [5];
        int exp_order [5];
        int n_g;
        int gi;
        logic [3:0] prev_g;
`ifdef ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 0, 1, 0};
`endif
        for (int i = 0; i < 4; i++) set_job(i, 1'b1, 8'(i * 16), 8'(i * 16));
        n_g = 0;
        prev_g = '0;
        post_req(4'b1111);
        for (int c = 0; c < 60 && n_g < 5; c++) begin
            @(negedge clk);
            if (gnt !== 4'b0 && prev_g === 4'b0) begin
                gi = -1;
                for (int k = 0; k < 4; k++) if (gnt[k]) gi = (gi == -1) ? k : -2;
                order[n_g] = gi;
                n_g++;
                if (n_g == 5) req = 4'b0;
            end
            prev_g = gnt;
        end
        n_total++; if (n_g != 5) $display("FAIL arb_grant_count: got %0d want 5", n_g); else n_pass++;
        for (int k = 0; k < n_g; k++) begin
            n_total++; if (order[k] != exp_order[k]) $display("FAIL arb_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]); else n_pass++;
        end
        wait_idle("arb");
    endtask

    task automatic test_abort();
        set_job(2, 1'b1, 8'd0, 8'd100);
        post_req(4'b0100);
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 7) begin
                n_total++; if (count !== 8'd5) $display("FAIL abort_pre_count: got %0d want 5", count); else n_pass++;
                abort = 1'b1;
            end
            if (c == 8) begin
                abort = 1'b0;
                req = 4'b0;
                n_total++; if (done !== 4'b0100) $display("FAIL abort_done: got %b want 0100", done); else n_pass++;
                n_total++; if (err !== 1'b1) $display("FAIL abort_err: got %b want 1", err); else n_pass++;
                n_total++; if (count !== 8'd5) $display("FAIL abort_count: got %0d want 5", count); else n_pass++;
                n_total++; if (gnt !== 4'b0) $display("FAIL abort_gnt: got %b want 0000", gnt); else n_pass++;
            end
            if (c == 9) begin
                n_total++; if (busy !== 1'b0 || done !== 4'b0 || err !== 1'b0) $display("FAIL abort_after: got busy=%b done=%b err=%b want 0/0000/0", busy, done, err); else n_pass++;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Zero-distance job with req held: also shows the one-cycle post-job mask.
    task automatic test_zero_distance();
        logic [3:0] eg;
        set_job(3, 1'b1, 8'd77, 8'd77);
        post_req(4'b1000);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            eg = (c == 1 || c == 2 || c == 6) ? 4'b1000 : 4'b0000;
            n_total++; if (gnt !== eg) $display("FAIL zero_gnt c%0d: got %b want %b", c, gnt, eg); else n_pass++;
            if (c == 2) begin
                n_total++; if (count !== 8'd77) $display("FAIL zero_count_run: got %0d want 77", count); else n_pass++;
            end
            if (c == 3) begin
                n_total++; if (done !== 4'b1000) $display("FAIL zero_done: got %b want 1000", done); else n_pass++;
                n_total++; if (count !== 8'd77) $display("FAIL zero_count_done: got %0d want 77", count); else n_pass++;
            end
            if (c == 4) begin
                n_total++; if (busy !== 1'b0) $display("FAIL zero_idle_busy: got %b want 0", busy); else n_pass++;
            end
            if (c == 6) req = 4'b0;
        end
        wait_idle("zero");
    endtask

    task automatic test_reset_mid_job();
        set_job(0, 1'b1, 8'd0, 8'd20);
        post_req(4'b0001);
        for (int c = 0; c <= 9; c++) @(negedge clk);
        n_total++; if (count !== 8'd7) $display("FAIL midrst_pre_count: got %0d want 7", count); else n_pass++;
        clr_n = 1'b0;
        #1;
        n_total++; if (count !== 8'd0) $display("FAIL midrst_count: got %0d want 0", count); else n_pass++;
        n_total++; if (gnt !== 4'b0) $display("FAIL midrst_gnt: got %b want 0000", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        req = 4'b0;
        #2 clr_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_total++; if (done !== 4'b0 || busy !== 1'b0) $display("FAIL midrst_quiet c%0d: got done=%b busy=%b want 0000/0", c, done, busy); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_up_job();
        test_down_wrap();
        test_arbitration();
        test_abort();
        test_zero_distance();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_job_sched.md
# count_job_sched

Round-robin scheduler that shares one W-bit loadable up/down counter among NREQ requesters. Each requester posts a counting job with start value, end value and direction. The block grants one job at a time, loads the counter, steps it to the end value with wrap-around, then signals completion. It sits between client control logic and the shared counter datapath, which is instantiated inline.

## Interface
- W, default 8: counter width in bits.
- NREQ, default 4: number of requesters (≥2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester job request; held high until done.
- mode  in  NREQ  per-requester direction: 1 = up, 0 = down.
- start_val  in  NREQ*W  packed start values; requester i is at [i*W +: W].
- end_val  in  NREQ*W  packed end values, same packing.
- abort  in  1  terminates the current job.
- gnt  out  NREQ  one-hot owner of the counter; high during LOAD and RUN.
- done  out  NREQ  one-hot, 1-cycle completion pulse.
- err  out  1  pulses with done when the job was aborted.
- busy  out  1  high whenever state ≠ IDLE.
- count  out  W  current counter value.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- Reset (clr_n low, asynchronous): state IDLE, count=0, gnt=0, done=0, err=0, busy=0, RR pointer=0. Reset takes effect mid-job, with no done.
- IDLE:
  - If any eligible req is high, the arbiter picks index g and goes to LOAD.
  - On that edge, gnt[g] sets and mode[g], start_val[g], end_val[g] are latched.
  - count holds.
- LOAD: count ← latched start, then go to RUN.
- RUN, each edge:
  - abort=1 → DONE with err set; count not stepped.
  - else count==end → DONE.
  - else count ← count±1 mod 2^W.
- DONE:
  - done[g]=1 for exactly one cycle; gnt=0; err=1 only if aborted.
  - Then go to IDLE.
- Post-job masking: in the IDLE cycle immediately after DONE, req[g] of the just-served requester is ignored. The same requester is never granted back-to-back.
- Input rules:
  - Changes to req, mode, start_val and end_val while granted are ignored.
  - abort in IDLE or DONE is ignored.
  - A req dropped before grant is simply not served.
- Arithmetic:
  - Unsigned, modulo 2^W; wrap-around is legal (up 250→3 passes 255→0).
  - Distance d = (end−start) mod 2^W for up, (start−end) mod 2^W for down.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- gnt is high from cycle 1. LOAD is cycle 1. RUN covers cycles 2 … d+2. done is high in cycle d+3.
- count shows start from cycle 2 and reaches end in cycle d+2.
- start==end: done in cycle 3 and count=start.
- Minimum spacing between consecutive grants: d+4 cycles (DONE→IDLE→LOAD).
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Configuration
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last g + 1) mod NREQ and the pointer updates on each grant.
- Undefined: fixed priority, lowest index wins, and the pointer logic is absent. Post-job masking still applies in both modes.

## Structure
- Package count_sched_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - default W and NREQ constants;
  - index-width localparam $clog2(NREQ).
- Sub-module count_rr_arb holds the request masking, the priority search and the RR pointer under ARB_RR_EN. It outputs a one-hot grant plus an encoded index.
- FSM and counter datapath live in count_job_sched.

## Test plan
All scenarios use W=8, NREQ=4.
- Reset: assert clr_n low during RUN at count=7 → count=0, gnt=0, busy=0 immediately, and no done pulse follows.
- Up job: req[1], start=10, end=13, mode=1 → gnt=0010 in cycles 1–5; count 10,11,12,13 in cycles 2–5; done=0010 in cycle 6; err=0.
- Down wrap: req[0], start=2, end=254, mode=0 → count 2,1,0,255,254; done[0] in cycle 7.
- Arbitration: req=1111 held continuously → ARB_RR_EN grant order is 0,1,2,3,0. Without it, the order is 0,1,0,1.
- Abort: req[2], start=0, end=100, up; abort asserted while count=5 → next cycle done=0100 and err=1, count holds 5, then IDLE.
- Zero distance: req[3], start=end=77 → done[3] in cycle 3 and count=77.
